multicycle_controller: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the select and command inputs of the instruction decoder, extender, ALU and load masker/extender from the decoder's opcode/funct fields and the ALU flags. It also owns the single shared memory port handshake used for both instruction fetch and data access.

---
 rtl/multicycle_controller.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and owns the shared memory port handshake for instruction and data accesses.
module multicycle_controller (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic [4:0] rd_i,
    input  logic       ab_eq_i,
    input  logic       c_sign_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic [3:0] mem_be_o,
    output logic       addr_src_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic [1:0] pc_src_o,
    output logic       alu_a_src_o,
    output logic       alu_b_src_o,
    output logic [2:0] alu_cmd_o,
    output logic [1:0] ext_cmd_o,
    output logic [2:0] mask_cmd_o,
    output logic       reg_we_o,
    output logic [1:0] wb_src_o,
    output logic       retire_o,
    output logic       illegal_o
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {K_ALU, K_BRANCH, K_JAL, K_JALR, K_LOAD, K_STORE} kind_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SR  = 3'b110;

    state_t     state_q, state_d;
    kind_t      kind_q, kind_d;
    logic       legal_d;
    logic [2:0] alu_cmd_q, alu_cmd_d;
    logic [1:0] ext_cmd_q, ext_cmd_d;
    logic [2:0] mask_cmd_q, mask_cmd_d;
    logic [3:0] mem_be_q, mem_be_d;
    logic       alu_a_src_q, alu_a_src_d;
    logic       alu_b_src_q, alu_b_src_d;
    logic [1:0] wb_src_q, wb_src_d;
    logic [1:0] br_sel_q;
    logic       rd_nz_q;
    logic       taken;

    // Only funct7[5] matters (SUB vs ADD); shift-arithmetic is resolved in the ALU.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};

    always_comb begin
        kind_d      = K_ALU;
        legal_d     = 1'b1;
        alu_cmd_d   = ALU_ADD;
        ext_cmd_d   = 2'b00;
        mask_cmd_d  = 3'b000;
        mem_be_d    = 4'b0000;
        alu_a_src_d = 1'b0;
        alu_b_src_d = 1'b0;
        wb_src_d    = 2'b00;
        case (opcode_i)
            OP_LUI: begin
                ext_cmd_d = 2'b01;
                wb_src_d  = 2'b11;
            end
            OP_AUIPC: begin
                ext_cmd_d   = 2'b01;
                alu_a_src_d = 1'b1;
                alu_b_src_d = 1'b1;
            end
            OP_JAL: begin
                kind_d    = K_JAL;
                ext_cmd_d = 2'b10;
                wb_src_d  = 2'b10;
            end
            OP_JALR: begin
                kind_d      = K_JALR;
                alu_b_src_d = 1'b1;
                wb_src_d    = 2'b10;
            end
            OP_BRANCH: begin
                kind_d    = K_BRANCH;
                alu_cmd_d = ALU_SUB;
                legal_d   = funct3_i inside {3'b000, 3'b001, 3'b110, 3'b111};
            end
            OP_LOAD: begin
                kind_d      = K_LOAD;
                alu_b_src_d = 1'b1;
                wb_src_d    = 2'b01;
                case (funct3_i)
                    3'b000:  mask_cmd_d = 3'b011;
                    3'b001:  mask_cmd_d = 3'b100;
                    3'b010:  mask_cmd_d = 3'b000;
                    3'b100:  mask_cmd_d = 3'b001;
                    3'b101:  mask_cmd_d = 3'b010;
                    default: legal_d    = 1'b0;
                endcase
            end
            OP_STORE: begin
                kind_d      = K_STORE;
                alu_b_src_d = 1'b1;
                case (funct3_i)
                    3'b000:  mem_be_d = 4'b0001;
                    3'b001:  mem_be_d = 4'b0011;
                    3'b010:  mem_be_d = 4'b1111;
                    default: legal_d  = 1'b0;
                endcase
            end
            OP_IMM, OP_REG: begin
                alu_b_src_d = (opcode_i == OP_IMM);
                case (funct3_i)
                    3'b000:  alu_cmd_d = (opcode_i == OP_REG && funct7_i[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_cmd_d = ALU_SLL;
                    3'b100:  alu_cmd_d = ALU_XOR;
                    3'b101:  alu_cmd_d = ALU_SR;
                    3'b110:  alu_cmd_d = ALU_OR;
                    3'b111:  alu_cmd_d = ALU_AND;
                    default: legal_d   = 1'b0;
                endcase
            end
            default: legal_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_FETCH;
            kind_q      <= K_ALU;
            alu_cmd_q   <= 3'b000;
            ext_cmd_q   <= 2'b00;
            mask_cmd_q  <= 3'b000;
            mem_be_q    <= 4'b0000;
            alu_a_src_q <= 1'b0;
            alu_b_src_q <= 1'b0;
            wb_src_q    <= 2'b00;
            br_sel_q    <= 2'b00;
            rd_nz_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                kind_q      <= kind_d;
                alu_cmd_q   <= alu_cmd_d;
                ext_cmd_q   <= ext_cmd_d;
                mask_cmd_q  <= mask_cmd_d;
                mem_be_q    <= mem_be_d;
                alu_a_src_q <= alu_a_src_d;
                alu_b_src_q <= alu_b_src_d;
                wb_src_q    <= wb_src_d;
                br_sel_q    <= {funct3_i[2], funct3_i[0]};
                rd_nz_q     <= (rd_i != 5'd0);
            end
        end
    end

    // funct3[2] picks the unsigned-compare pair, funct3[0] inverts the condition.
    assign taken = br_sel_q[1] ? (c_sign_i ^ br_sel_q[0]) : (ab_eq_i ^ br_sel_q[0]);

    always_comb begin
        state_d     = state_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        addr_src_o  = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_src_o    = 2'b00;
        alu_a_src_o = 1'b0;
        alu_b_src_o = 1'b0;
        alu_cmd_o   = 3'b000;
        ext_cmd_o   = 2'b00;
        mask_cmd_o  = 3'b000;
        reg_we_o    = 1'b0;
        wb_src_o    = 2'b00;
        retire_o    = 1'b0;
        illegal_o   = 1'b0;
        // Reset forces every output low, including an access in flight.
        if (!rst_i) begin
            if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
                alu_a_src_o = alu_a_src_q;
                alu_b_src_o = alu_b_src_q;
                alu_cmd_o   = alu_cmd_q;
                ext_cmd_o   = ext_cmd_q;
                mask_cmd_o  = mask_cmd_q;
                wb_src_o    = wb_src_q;
            end
            case (state_q)
                S_FETCH: begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_we_o = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: state_d = legal_d ? S_EXEC : S_TRAP;
                S_EXEC: begin
                    case (kind_q)
                        K_BRANCH: begin
                            pc_we_o  = 1'b1;
                            pc_src_o = taken ? 2'b01 : 2'b00;
                            retire_o = 1'b1;
                            state_d  = S_FETCH;
                        end
                        K_JAL, K_JALR: begin
                            reg_we_o = rd_nz_q;
                            pc_we_o  = 1'b1;
                            pc_src_o = (kind_q == K_JAL) ? 2'b01 : 2'b10;
                            retire_o = 1'b1;
                            state_d  = S_FETCH;
                        end
                        K_LOAD, K_STORE: state_d = S_MEM;
                        default:         state_d = S_WB;
                    endcase
                end
                S_MEM: begin
                    mem_req_o  = 1'b1;
                    addr_src_o = 1'b1;
                    mem_we_o   = (kind_q == K_STORE);
                    mem_be_o   = mem_be_q;
                    if (mem_ready_i) begin
                        if (kind_q == K_STORE) begin
                            pc_we_o  = 1'b1;
                            retire_o = 1'b1;
                            state_d  = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_we_o = rd_nz_q;
                    pc_we_o  = 1'b1;
                    retire_o = 1'b1;
                    state_d  = S_FETCH;
                end
                S_TRAP:  illegal_o = 1'b1;
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output snapshots of each
// instruction are compared against hand-derived sequences.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic [4:0] rd = 5'd0;
    logic       ab_eq = 1'b0;
    logic       c_sign = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, addr_src, ir_we, pc_we;
    logic [3:0] mem_be;
    logic [1:0] pc_src, ext_cmd, wb_src;
    logic       alu_a_src, alu_b_src, reg_we, retire, illegal;
    logic [2:0] alu_cmd, mask_cmd;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic [3:0] mem_be;
        logic       addr_src;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_a_src;
        logic       alu_b_src;
        logic [2:0] alu_cmd;
        logic [1:0] ext_cmd;
        logic [2:0] mask_cmd;
        logic       reg_we;
        logic [1:0] wb_src;
        logic       retire;
        logic       illegal;
    } snap_t;

    snap_t snap [0:15];
    int    ncyc;
    logic  any_reg_we;
    int    n_retire;

    multicycle_controller dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
        .rd_i(rd), .ab_eq_i(ab_eq), .c_sign_i(c_sign), .mem_ready_i(mem_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .addr_src_o(addr_src),
        .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_src_o(pc_src), .alu_a_src_o(alu_a_src),
        .alu_b_src_o(alu_b_src), .alu_cmd_o(alu_cmd), .ext_cmd_o(ext_cmd),
        .mask_cmd_o(mask_cmd), .reg_we_o(reg_we), .wb_src_o(wb_src), .retire_o(retire),
        .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic snap_t cur_snap();
        return {mem_req, mem_we, mem_be, addr_src, ir_we, pc_we, pc_src, alu_a_src,
                alu_b_src, alu_cmd, ext_cmd, mask_cmd, reg_we, wb_src, retire, illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        tick();
        check("rst_outs", cur_snap(), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_fetch", mem_req, 1'b1);
    endtask

    // Acts as a memory with fw/mw wait cycles; records outputs until retire.
    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] r, input int fw, input int mw,
                       input logic eq, input logic cs);
        int w;
        opcode = op; funct3 = f3; funct7 = f7; rd = r; ab_eq = eq; c_sign = cs;
        ncyc = 0; any_reg_we = 1'b0; n_retire = 0; w = 0;
        for (int i = 0; i < 16; i++) begin
            mem_ready = mem_req && (w == (addr_src ? mw : fw));
            #1;
            snap[i] = cur_snap();
            any_reg_we |= reg_we;
            w = (mem_req && !mem_ready) ? w + 1 : 0;
            if (retire) begin
                ncyc = i + 1;
                n_retire++;
                break;
            end
            @(posedge clk);
            #1;
        end
        tick();
        mem_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] trap_bad;
        do_reset();

        // ADDI x1,x0,5
        run(7'b0010011, 3'b000, 7'd0, 5'd1, 0, 0, 1'b0, 1'b0);
        check("addi_cycles", ncyc, 4);
        check("addi_ir_we", snap[0].ir_we, 1'b1);
        check("addi_dec_req", snap[1].mem_req, 1'b0);
        check("addi_wb_reg_we", snap[3].reg_we, 1'b1);
        check("addi_wb_src", snap[3].wb_src, 2'b00);
        check("addi_alu_cmd", snap[3].alu_cmd, 3'b000);
        check("addi_b_src", snap[3].alu_b_src, 1'b1);
        check("addi_pc", {snap[3].pc_we, snap[3].pc_src}, 3'b100);

        // LH x2,0(x1) with two MEM wait cycles
        run(7'b0000011, 3'b001, 7'd0, 5'd2, 0, 2, 1'b0, 1'b0);
        check("lh_cycles", ncyc, 7);
        for (int i = 3; i < 6; i++)
            check($sformatf("lh_mem%0d", i), {snap[i].mem_req, snap[i].addr_src, snap[i].mem_we, snap[i].mem_be}, 7'b1100000);
        check("lh_mask", snap[6].mask_cmd, 3'b100);
        check("lh_wb_src", snap[6].wb_src, 2'b01);
        check("lh_reg_we", snap[6].reg_we, 1'b1);

        // Branches
        run(7'b1100011, 3'b001, 7'd0, 5'd0, 0, 0, 1'b1, 1'b0);
        check("bne_eq_cycles", ncyc, 3);
        check("bne_eq_pc", {snap[2].pc_we, snap[2].pc_src}, 3'b100);
        check("bne_alu_cmd", snap[2].alu_cmd, 3'b001);
        run(7'b1100011, 3'b001, 7'd0, 5'd0, 0, 0, 1'b0, 1'b0);
        check("bne_ne_cycles", ncyc, 3);
        check("bne_ne_pc", snap[2].pc_src, 2'b01);
        run(7'b1100011, 3'b110, 7'd0, 5'd0, 0, 0, 1'b0, 1'b1);
        check("bltu_cycles", ncyc, 3);
        check("bltu_pc", snap[2].pc_src, 2'b01);
        run(7'b1100011, 3'b000, 7'd0, 5'd0, 0, 0, 1'b1, 1'b0);
        check("beq_pc", snap[2].pc_src, 2'b01);
        run(7'b1100011, 3'b111, 7'd0, 5'd0, 0, 0, 1'b0, 1'b1);
        check("bgeu_pc", snap[2].pc_src, 2'b00);

        // SB x3,4(x1)
        run(7'b0100011, 3'b000, 7'd0, 5'd4, 0, 0, 1'b0, 1'b0);
        check("sb_cycles", ncyc, 4);
        check("sb_mem", {snap[3].mem_req, snap[3].mem_we, snap[3].addr_src, snap[3].mem_be}, 7'b1110001);
        check("sb_pc", {snap[3].pc_we, snap[3].pc_src}, 3'b100);
        check("sb_no_reg_we", any_reg_we, 1'b0);

        // SW with one wait cycle: request stays stable
        run(7'b0100011, 3'b010, 7'd0, 5'd0, 0, 1, 1'b0, 1'b0);
        check("sw_cycles", ncyc, 5);
        check("sw_hold", {snap[3].mem_we, snap[3].mem_be, snap[4].mem_we, snap[4].mem_be}, 10'b11111_11111);

        // ADD x0,x1,x2 and SUB x5
        run(7'b0110011, 3'b000, 7'd0, 5'd0, 0, 0, 1'b0, 1'b0);
        check("add_x0_cycles", ncyc, 4);
        check("add_x0_reg_we", any_reg_we, 1'b0);
        check("add_x0_retire", n_retire, 1);
        run(7'b0110011, 3'b000, 7'b0100000, 5'd5, 0, 0, 1'b0, 1'b0);
        check("sub_alu_cmd", snap[2].alu_cmd, 3'b001);
        check("sub_b_src", snap[3].alu_b_src, 1'b0);

        // JAL / JALR / LUI / AUIPC
        run(7'b1101111, 3'b000, 7'd0, 5'd1, 0, 0, 1'b0, 1'b0);
        check("jal_cycles", ncyc, 3);
        check("jal_exec", {snap[2].reg_we, snap[2].wb_src, snap[2].pc_we, snap[2].pc_src, snap[2].ext_cmd}, 8'b1_10_1_01_10);
        run(7'b1100111, 3'b000, 7'd0, 5'd1, 0, 0, 1'b0, 1'b0);
        check("jalr_cycles", ncyc, 3);
        check("jalr_exec", {snap[2].reg_we, snap[2].wb_src, snap[2].pc_src, snap[2].alu_b_src}, 6'b1_10_10_1);
        run(7'b0110111, 3'b000, 7'd0, 5'd3, 0, 0, 1'b0, 1'b0);
        check("lui_cycles", ncyc, 4);
        check("lui_wb", {snap[3].wb_src, snap[3].ext_cmd}, 4'b1101);
        run(7'b0010111, 3'b000, 7'd0, 5'd3, 0, 0, 1'b0, 1'b0);
        check("auipc_srcs", {snap[2].alu_a_src, snap[2].alu_b_src, snap[2].ext_cmd}, 4'b1101);

        // Fetch wait adds one cycle
        run(7'b0010011, 3'b000, 7'd0, 5'd1, 1, 0, 1'b0, 1'b0);
        check("addi_fwait_cycles", ncyc, 5);

        // Illegal opcode, then SLT
        for (int t = 0; t < 2; t++) begin
            opcode = (t == 0) ? 7'b1111111 : 7'b0110011;
            funct3 = (t == 0) ? 3'b000 : 3'b010;
            rd = 5'd1;
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            tick();
            trap_bad = 0;
            mem_ready = 1'b1;
            for (int c = 0; c < 5; c++) begin
                #1;
                if ({mem_req, mem_we, ir_we, pc_we, reg_we, retire, illegal} != 7'b0000001)
                    trap_bad++;
                tick();
            end
            mem_ready = 1'b0;
            check($sformatf("trap%0d_state", t), {illegal, mem_req, retire}, 3'b100);
            check($sformatf("trap%0d_held", t), trap_bad, 0);
            do_reset();
        end

        // Reset during the MEM cycle of a store
        opcode = 7'b0100011; funct3 = 3'b010; rd = 5'd0;
        mem_ready = 1'b1;
        #1;
        check("abort_fetch_ir_we", ir_we, 1'b1);
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        check("abort_in_mem", {mem_req, mem_we, addr_src}, 3'b111);
        rst = 1'b1;
        #1;
        check("abort_rst_outs", cur_snap(), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_refetch", {mem_req, mem_we, addr_src, pc_we}, 4'b1000);
        run(7'b0010011, 3'b000, 7'd0, 5'd1, 0, 0, 1'b0, 1'b0);
        check("abort_next_cycles", ncyc, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
